// File: rtl/m3_round_len_calc_pkg.sv
// Shared widths, FSM state type and clamp helper for the round-length responder.
package m3_round_len_calc_pkg;

    localparam int unsigned SPEED_W = 16;
    localparam int unsigned LEN_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] v,
        input logic [LEN_W-1:0] lo,
        input logic [LEN_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/m3_round_len_calc_serial_div.sv
// 32/16 restoring divider: one quotient bit per cycle, the load cycle performs the first step,
// so the quotient is ready 32 edges after startI.
module m3_round_len_calc_serial_div
    import m3_round_len_calc_pkg::*;
(
    input  logic               clkI,
    input  logic               rstI,
    input  logic               startI,
    input  logic               abortI,
    input  logic [LEN_W-1:0]   numI,
    input  logic [SPEED_W-1:0] denI,
    output logic [LEN_W-1:0]   quoO,
    output logic               doneO
);
    localparam int unsigned CNT_W = 5;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SPEED_W-1:0] rem_q, rem_d;
    logic [SPEED_W-1:0] den_q, den_d;
    logic [LEN_W-1:0]   sh_q, sh_d;

    logic [SPEED_W-1:0] rem_in_c;
    logic [SPEED_W-1:0] den_in_c;
    logic [LEN_W-1:0]   num_in_c;
    logic [SPEED_W:0]   rem_sh_c;
    logic               ge_c;

    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        den_d    = den_q;
        sh_d     = sh_q;
        rem_in_c = startI ? '0 : rem_q;
        num_in_c = startI ? numI : sh_q;
        den_in_c = startI ? denI : den_q;
        rem_sh_c = {rem_in_c, num_in_c[LEN_W-1]};
        ge_c     = rem_sh_c >= {1'b0, den_in_c};
        if (abortI) begin
            busy_d = 1'b0;
        end else if (startI || busy_q) begin
            // sh shifts out dividend bits on top and collects quotient bits at the bottom
            rem_d  = ge_c ? SPEED_W'(rem_sh_c - {1'b0, den_in_c}) : rem_sh_c[SPEED_W-1:0];
            sh_d   = {num_in_c[LEN_W-2:0], ge_c};
            den_d  = den_in_c;
            busy_d = 1'b1;
            cnt_d  = startI ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (!startI && (cnt_q == '1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clkI) begin
        if (rstI) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            sh_q   <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            sh_q   <= sh_d;
        end
    end

    assign quoO  = sh_q;
    assign doneO = done_q;

endmodule

// File: rtl/m3_round_len_calc.sv
// Round-length responder: tracks target/current speed and, per request, ramps the current
// speed and divides DIV_NUM by it to produce a clamped per-step period.
module m3_round_len_calc
    import m3_round_len_calc_pkg::*;
#(
    parameter logic [LEN_W-1:0]   DIV_NUM    = 32'd1_000_000,
    parameter logic [SPEED_W-1:0] SPEED_MIN  = 16'd10,
    parameter logic [SPEED_W-1:0] SPEED_MAX  = 16'd1000,
    parameter logic [SPEED_W-1:0] SPEED_STEP = 16'd10,
    parameter logic [SPEED_W-1:0] ACCEL_STEP = 16'd20,
    parameter logic [LEN_W-1:0]   LEN_MIN    = 32'd64,
    parameter logic [LEN_W-1:0]   LEN_MAX    = 32'h3FFFFF
) (
    input  logic               clkI,
    input  logic               rstI,
    input  logic               m3startI,
    input  logic               m3forceStopI,
    input  logic               m3speedINCi,
    input  logic               m3speedDECi,
    input  logic               nextCalc_1i,
    output logic [LEN_W-1:0]   dstRoundLenO,
    output logic               busyO,
    output logic               doneO,
    output logic               overrunO,
    output logic [SPEED_W-1:0] speedCurO,
    output logic [SPEED_W-1:0] speedTgtO
);
    state_e             state_q, state_d;
    logic [SPEED_W-1:0] cur_q, cur_d;
    logic [SPEED_W-1:0] tgt_q, tgt_d;
    logic [LEN_W-1:0]   dst_q, dst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;

    logic               stop_c;
    logic [SPEED_W:0]   tgt_inc_c, tgt_dec_c;
    logic [SPEED_W-1:0] ramp_diff_c, ramp_step_c;
    logic               div_start_c, div_abort_c, div_done_c;
    logic [LEN_W-1:0]   div_quo_c;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        tgt_d       = tgt_q;
        dst_d       = dst_q;
        done_d      = 1'b0;
        ovr_d       = ovr_q;
        div_start_c = 1'b0;
        stop_c      = m3forceStopI | ~m3startI;
        div_abort_c = stop_c;
        tgt_inc_c   = {1'b0, tgt_q} + {1'b0, SPEED_STEP};
        tgt_dec_c   = {1'b0, tgt_q} - {1'b0, SPEED_STEP};
        ramp_diff_c = (tgt_q > cur_q) ? tgt_q - cur_q : cur_q - tgt_q;
        ramp_step_c = (ramp_diff_c > ACCEL_STEP) ? ACCEL_STEP : ramp_diff_c;

        if (stop_c) begin
            state_d = ST_IDLE;
            dst_d   = LEN_MAX;
            cur_d   = SPEED_MIN;
            tgt_d   = SPEED_MIN;
            if (!m3startI) ovr_d = 1'b0;
        end else begin
            if (m3speedINCi && !m3speedDECi) begin
                tgt_d = (tgt_inc_c > {1'b0, SPEED_MAX}) ? SPEED_MAX : tgt_inc_c[SPEED_W-1:0];
            end else if (m3speedDECi && !m3speedINCi) begin
                // bit 16 set means the subtraction wrapped below zero
                tgt_d = (tgt_dec_c[SPEED_W] || (tgt_dec_c < {1'b0, SPEED_MIN}))
                        ? SPEED_MIN : tgt_dec_c[SPEED_W-1:0];
            end
            if (nextCalc_1i && (state_q != ST_IDLE)) ovr_d = 1'b1;
            case (state_q)
                ST_IDLE: if (nextCalc_1i) state_d = ST_RAMP;
                ST_RAMP: begin
                    cur_d       = (tgt_q > cur_q) ? cur_q + ramp_step_c : cur_q - ramp_step_c;
                    div_start_c = 1'b1;
                    state_d     = ST_DIV;
                end
                ST_DIV:  if (div_done_c) state_d = ST_DONE;
                ST_DONE: begin
                    dst_d   = clamp_len(div_quo_c, LEN_MIN, LEN_MAX);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_RAMP) || (state_d == ST_DIV);
    end

    // divider loads the freshly ramped speed on the RAMP->DIV edge
    m3_round_len_calc_serial_div u_div (
        .clkI   (clkI),
        .rstI   (rstI),
        .startI (div_start_c),
        .abortI (div_abort_c),
        .numI   (DIV_NUM),
        .denI   (cur_d),
        .quoO   (div_quo_c),
        .doneO  (div_done_c)
    );

    always_ff @(posedge clkI) begin
        if (rstI) begin
            state_q <= ST_IDLE;
            cur_q   <= SPEED_MIN;
            tgt_q   <= SPEED_MIN;
            dst_q   <= LEN_MAX;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            dst_q   <= dst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dstRoundLenO = dst_q;
    assign busyO        = busy_q;
    assign doneO        = done_q;
    assign overrunO     = ovr_q;
    assign speedCurO    = cur_q;
    assign speedTgtO    = tgt_q;

endmodule

// File: tb/tb_m3_round_len_calc.sv
// Bench for m3_round_len_calc: three instances differing only in DIV_NUM share one stimulus
// stream and are compared every cycle against a countdown-based reference model.
module tb_m3_round_len_calc;

    logic clk = 1'b0;
    logic rst, start, fstop, inc, dec, nc;

    logic [31:0] len_a, len_b, len_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        ovr_a, ovr_b, ovr_c;
    logic [15:0] cur_a, cur_b, cur_c;
    logic [15:0] tgt_a, tgt_b, tgt_c;

    int total = 0;
    int bad   = 0;

    localparam longint DIV_A = 64'd1_000_000;
    localparam longint DIV_B = 64'd1000;
    localparam longint DIV_C = 64'hFFFF_FFFF;

    // reference model state
    int     m_tgt, m_cur, m_cnt;
    bit     m_done, m_ovr;
    longint m_len_a, m_len_b, m_len_c;

    always #5 clk = ~clk;

    m3_round_len_calc u_dut_a (
        .clkI(clk), .rstI(rst), .m3startI(start), .m3forceStopI(fstop),
        .m3speedINCi(inc), .m3speedDECi(dec), .nextCalc_1i(nc),
        .dstRoundLenO(len_a), .busyO(busy_a), .doneO(done_a), .overrunO(ovr_a),
        .speedCurO(cur_a), .speedTgtO(tgt_a)
    );

    m3_round_len_calc #(.DIV_NUM(32'd1000)) u_dut_b (
        .clkI(clk), .rstI(rst), .m3startI(start), .m3forceStopI(fstop),
        .m3speedINCi(inc), .m3speedDECi(dec), .nextCalc_1i(nc),
        .dstRoundLenO(len_b), .busyO(busy_b), .doneO(done_b), .overrunO(ovr_b),
        .speedCurO(cur_b), .speedTgtO(tgt_b)
    );

    m3_round_len_calc #(.DIV_NUM(32'hFFFF_FFFF)) u_dut_c (
        .clkI(clk), .rstI(rst), .m3startI(start), .m3forceStopI(fstop),
        .m3speedINCi(inc), .m3speedDECi(dec), .nextCalc_1i(nc),
        .dstRoundLenO(len_c), .busyO(busy_c), .doneO(done_c), .overrunO(ovr_c),
        .speedCurO(cur_c), .speedTgtO(tgt_c)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint period_of(input longint num, input int speed);
        longint q;
        q = num / longint'(speed);
        if (q < 64) q = 64;
        if (q > 64'h3FFFFF) q = 64'h3FFFFF;
        return q;
    endfunction

    // m_cnt = edges left until a new period is registered (0 = idle)
    task automatic model_step(input bit r, input bit st, input bit fs, input bit i, input bit d, input bit n);
        m_done = 1'b0;
        if (r || fs || !st) begin
            m_cnt = 0; m_cur = 10; m_tgt = 10;
            m_len_a = 64'h3FFFFF; m_len_b = 64'h3FFFFF; m_len_c = 64'h3FFFFF;
            if (r || !st) m_ovr = 1'b0;
            return;
        end
        if (m_cnt == 0) begin
            if (n) m_cnt = 34;
        end else begin
            if (n) m_ovr = 1'b1;
            if (m_cnt == 34) begin
                if (m_tgt > m_cur) m_cur = m_cur + ((m_tgt - m_cur) > 20 ? 20 : (m_tgt - m_cur));
                else               m_cur = m_cur - ((m_cur - m_tgt) > 20 ? 20 : (m_cur - m_tgt));
            end
            m_cnt--;
            if (m_cnt == 0) begin
                m_done  = 1'b1;
                m_len_a = period_of(DIV_A, m_cur);
                m_len_b = period_of(DIV_B, m_cur);
                m_len_c = period_of(DIV_C, m_cur);
            end
        end
        if (i && !d)      m_tgt = (m_tgt + 10 > 1000) ? 1000 : m_tgt + 10;
        else if (d && !i) m_tgt = (m_tgt - 10 < 10) ? 10 : m_tgt - 10;
    endtask

    task automatic check_all();
        chk("len_a", len_a, m_len_a);
        chk("len_b", len_b, m_len_b);
        chk("len_c", len_c, m_len_c);
        chk("busy",  busy_a, (m_cnt >= 2));
        chk("done",  done_a, m_done);
        chk("ovr",   ovr_a, m_ovr);
        chk("cur",   cur_a, m_cur);
        chk("tgt",   tgt_a, m_tgt);
        chk("twins", {busy_b, done_b, ovr_b, cur_b, busy_c, done_c, ovr_c, cur_c},
                     {busy_a, done_a, ovr_a, cur_a, busy_a, done_a, ovr_a, cur_a});
    endtask

    task automatic cyc(input bit r, input bit st, input bit fs, input bit i, input bit d, input bit n);
        @(negedge clk);
        rst = r; start = st; fstop = fs; inc = i; dec = d; nc = n;
        @(posedge clk);
        model_step(r, st, fs, i, d, n);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 1, 0, 0, 0, 0);
    endtask

    int done_seen;

    initial begin
        rst = 1'b1; start = 1'b0; fstop = 1'b0; inc = 1'b0; dec = 1'b0; nc = 1'b0;
        m_tgt = 10; m_cur = 10; m_cnt = 0; m_done = 0; m_ovr = 0;
        m_len_a = 64'h3FFFFF; m_len_b = 64'h3FFFFF; m_len_c = 64'h3FFFFF;

        repeat (3) cyc(1, 1, 0, 0, 0, 0);
        idle(2);

        // single request at minimum speed, with an explicit latency count
        cyc(0, 1, 0, 0, 0, 1);
        done_seen = 0;
        for (int k = 2; k <= 40; k++) begin
            cyc(0, 1, 0, 0, 0, 0);
            if (done_a && done_seen == 0) done_seen = k;
        end
        chk("latency", done_seen, 35);
        chk("len_100000", len_a, 100000);

        // target 60, three ramps
        repeat (5) cyc(0, 1, 0, 1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            cyc(0, 1, 0, 0, 0, 1);
            idle(36);
        end
        chk("len_16666", len_a, 16666);

        // saturate target at max, then simultaneous INC+DEC
        repeat (200) cyc(0, 1, 0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 1, 1, 0);
        chk("tgt_max", tgt_a, 1000);

        // overrun: second request at cycle 10 of DIV
        cyc(0, 1, 0, 0, 0, 1);
        idle(10);
        cyc(0, 1, 0, 0, 0, 1);
        idle(30);

        // force stop mid-divide
        cyc(0, 1, 0, 0, 0, 1);
        idle(10);
        cyc(0, 1, 1, 0, 0, 1);
        chk("stop_len", len_a, 4194303);
        idle(30);

        // ramp all the way to 1000 for low clamp on the small-numerator instance
        repeat (100) cyc(0, 1, 0, 1, 0, 0);
        for (int r = 0; r < 50; r++) begin
            cyc(0, 1, 0, 0, 0, 1);
            idle(35);
        end
        chk("len_b_min", len_b, 64);

        // start low clears overrun
        cyc(0, 0, 0, 0, 0, 0);
        idle(2);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            cyc($urandom_range(0, 499) == 0,
                $urandom_range(0, 299) != 0,
                $urandom_range(0, 199) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
